ram_fifo: RTL and testbench
===========================

# ram_fifo

Single-clock, RAM-backed first-in/first-out buffer of 2**DEPTH words of WIDTH bits. Stores data in a dual-port register array addressed by wrapping read and write pointers. Provides shift-in/shift-out handshakes with full/empty flags, and presents the oldest stored word on rdata at all times (show-ahead). Serves as the generic elastic buffer between a producer and a consumer in the same clock domain.

## Interface
- WIDTH, default 8: data word width in bits.
- DEPTH, default 8: address width in bits. Capacity is 2**DEPTH words (256 by default).

- clk  input  1  clock; all state changes on the rising edge.
- res_n  input  1  reset; asynchronous and active-low.
- shift_in  input  1  write request; wdata is pushed at the rising edge.
- shift_out  input  1  read request; the head word is popped at the rising edge.
- wdata  input  WIDTH  write data.
- full  output  1  high when 2**DEPTH words are stored.
- empty  output  1  high when 0 words are stored.
- rdata  output  WIDTH  oldest stored word; 0 when empty.

## Operation
- Storage is a 2**DEPTH x WIDTH register array with a synchronous write port and an asynchronous read port. Memory contents are not reset.
- Write pointer wr_ptr and read pointer rd_ptr are DEPTH bits wide and wrap modulo 2**DEPTH.
- Occupancy counter count is DEPTH+1 bits wide, ranging 0..2**DEPTH.
- full = (count == 2**DEPTH); empty = (count == 0). Both are decoded from the registered count.
- rdata = empty ? 0 : mem[rd_ptr].
- Effective operations per rising edge:
  - do_write = shift_in & (!full | shift_out)
  - do_read = shift_out & !empty
- On do_write: mem[wr_ptr] <= wdata; wr_ptr++.
- On do_read: rd_ptr++.
- Counter update:
  - count+1 on write only.
  - count-1 on read only.
  - Unchanged when both or neither occur.
- Boundary rules:
  - shift_in while full with shift_out=0: ignored; no data or pointer change.
  - shift_out while empty: ignored.
  - Both asserted while empty: write only; count becomes 1.
  - Both asserted while full: simultaneous pop and push; count stays 2**DEPTH. The slot being freed is the slot written; the new word becomes the youngest.
  - Both asserted otherwise: pop and push; count unchanged.
- Pointer wrap from 2**DEPTH-1 to 0 is transparent; ordering is preserved across wrap.
- Reset (res_n=0), at any time including mid-operation: wr_ptr, rd_ptr and count clear to 0 immediately. All stored data is discarded.

## Timing
- Reset values: empty=1, full=0, rdata=0.
- Write-to-read latency is 0 cycles after the accepting edge. A word written at edge k into an empty FIFO makes empty=0 and rdata=that word immediately after edge k.
- After a pop at edge k, rdata shows the next word (or 0 if now empty) immediately after edge k.
- Flags update only at rising edges or asynchronously on reset, never combinationally from shift_in/shift_out.
- Inputs are sampled at the rising edge. The environment changes them away from the rising edge; testbenches drive on the falling edge.
- Throughput is one push and one pop per cycle.

## Test plan
- Reset held 100 time units then released -> empty=1, full=0, rdata=0. Then 256 consecutive pushes of random data -> full rises after the 256th edge; empty=0 after the first.
- From full, hold shift_out until empty -> 256 words appear on rdata in write order; empty=1 after the 256th pop; one further shift_out is ignored (count stays 0).
- From empty, 256 cycles with shift_in=shift_out=1 -> first cycle write only; then count stays 1 throughout; each popped word equals the word pushed one cycle earlier.
- Continuing with 40 pushes (total 41 stored), then drain -> exactly 41 words out in order, verified against a scoreboard; pointers have wrapped past 255 with no corruption.
- With the FIFO full, shift_in=1 and shift_out=0 for several cycles -> contents, full and rdata unchanged. Then shift_in=shift_out=1 -> full stays 1, head advances, and the new word appears last on drain.
- Assert res_n=0 asynchronously between edges with 10 words stored -> empty=1, full=0 and rdata=0 immediately; a subsequent push/pop works from an empty state.

Source files
------------

// File: rtl/ram_fifo.sv
// Single-clock show-ahead FIFO backed by a 2**DEPTH x WIDTH register array.
// The head word is always on rdata; a pop and a push may share an edge even when full.
module ram_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             res_n,
    input  logic             shift_in,
    input  logic             shift_out,
    input  logic [WIDTH-1:0] wdata,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] rdata
);

    localparam int unsigned    CAP     = 1 << DEPTH;
    localparam logic [DEPTH:0] CAP_CNT = (DEPTH + 1)'(CAP);
    localparam logic [DEPTH-1:0] PTR_ONE = DEPTH'(1);
    localparam logic [DEPTH:0]   CNT_ONE = (DEPTH + 1)'(1);

    logic [WIDTH-1:0] mem_q [CAP];
    logic [DEPTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH:0]   count_q, count_d;
    logic             do_write;
    logic             do_read;

    assign full  = (count_q == CAP_CNT);
    assign empty = (count_q == '0);
    assign rdata = empty ? '0 : mem_q[rd_ptr_q];

    // A push into a full FIFO is only legal when the head leaves on the same edge.
    assign do_write = shift_in & (~full | shift_out);
    assign do_read  = shift_out & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_write) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (do_read) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({do_write, do_read})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; stale words are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: tb/tb_ram_fifo.sv
// Randomised bench for ram_fifo: a queue-based reference model feeds a scoreboard
// that a separate monitor drains whenever the consumer takes the head word.
module tb_ram_fifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;
    localparam int CAP   = 1 << DEPTH;

    logic             clk;
    logic             res_n;
    logic             shift_in;
    logic             shift_out;
    logic [WIDTH-1:0] wdata;
    logic             full;
    logic             empty;
    logic [WIDTH-1:0] rdata;

    int checks = 0;
    int errors = 0;

    // Reference: exp_q holds every accepted word, oldest first; model_count is occupancy.
    logic [WIDTH-1:0] exp_q[$];
    int               model_count = 0;

    ram_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .res_n     (res_n),
        .shift_in  (shift_in),
        .shift_out (shift_out),
        .wdata     (wdata),
        .full      (full),
        .empty     (empty),
        .rdata     (rdata)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- check helper ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    always @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            model_count = 0;
            exp_q.delete();
        end else begin
            bit wr, rd;
            rd = shift_out && (model_count > 0);
            wr = shift_in && ((model_count < CAP) || shift_out);
            if (wr) exp_q.push_back(wdata);
            if (wr && !rd) model_count++;
            if (rd && !wr) model_count--;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        forever begin
            @(negedge clk);
            #1;
            check("empty", 32'(empty), 32'(model_count == 0));
            check("full",  32'(full),  32'(model_count == CAP));
            if (model_count == 0) begin
                check("rdata_empty", 32'(rdata), 32'd0);
            end else if (exp_q.size() == 0) begin
                check("scoreboard_underflow", 32'(exp_q.size()), 32'(model_count));
            end else if (shift_out) begin
                check("pop_data", 32'(rdata), 32'(exp_q.pop_front()));
            end else begin
                check("head_data", 32'(rdata), 32'(exp_q[0]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cycle(input bit si, input bit so, input logic [WIDTH-1:0] wd);
        @(negedge clk);
        shift_in  = si;
        shift_out = so;
        wdata     = wd;
    endtask

    task automatic push_n(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, WIDTH'($urandom));
    endtask

    task automatic pop_n(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, WIDTH'($urandom));
    endtask

    task automatic both_n(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b1, WIDTH'($urandom));
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, WIDTH'($urandom));
    endtask

    task automatic random_n(input int n, input int pin, input int pout);
        for (int i = 0; i < n; i++) begin
            cycle(($urandom_range(0, 99) < pin), ($urandom_range(0, 99) < pout), WIDTH'($urandom));
        end
    endtask

    // Reset asserted between edges; flags and rdata must clear without waiting for a clock.
    task automatic async_reset_mid();
        @(negedge clk);
        shift_in  = 1'b0;
        shift_out = 1'b0;
        #3;
        res_n = 1'b0;
        #1;
        check("async_rst_empty", 32'(empty), 32'd1);
        check("async_rst_full",  32'(full),  32'd0);
        check("async_rst_rdata", 32'(rdata), 32'd0);
        @(negedge clk);
        #3;
        res_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        res_n     = 1'b0;
        shift_in  = 1'b0;
        shift_out = 1'b0;
        wdata     = '0;
        #100;
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full",  32'(full),  32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        #3;
        res_n = 1'b1;

        // Fill to capacity, then drain fully plus one ignored pop.
        push_n(CAP);
        idle_n(1);
        check("full_after_fill", 32'(full), 32'd1);
        pop_n(CAP);
        pop_n(1);
        idle_n(1);
        check("empty_after_drain", 32'(empty), 32'd1);

        // Simultaneous push/pop from empty: first edge writes only, then count holds at 1.
        both_n(CAP);
        check("pass_through_not_empty", 32'(empty), 32'd0);

        // Grow to 41 words across the pointer wrap, then drain.
        push_n(40);
        pop_n(45);

        // Push into a full FIFO is ignored; push+pop while full rotates the contents.
        push_n(CAP);
        push_n(5);
        both_n(3);
        idle_n(1);
        check("full_after_rotate", 32'(full), 32'd1);
        pop_n(CAP + 2);

        // Asynchronous reset with 10 words stored, then normal operation resumes.
        push_n(10);
        async_reset_mid();
        push_n(3);
        both_n(4);
        pop_n(5);

        // Random traffic with biases that visit both full and empty.
        random_n(600, 85, 25);
        random_n(600, 25, 85);
        random_n(600, 50, 50);
        pop_n(CAP + 2);
        idle_n(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
